// File: rtl/surf6_fwu_bank_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | surf6_fwu_bank_tracker: N-bank firmware-update handshake tracker (WB clk) |
// | Optional macro FWU_TIMEOUT_EN enables per-bank MARKED stall timeouts.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module surf6_fwu_bank_tracker #(
  parameter int NBANKS         = 2,
  parameter int CNTW           = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                        wb_clk_i,
  input  logic                                        wb_rst_n_i,
  input  logic                                        fw_downloadmode_i,
  input  logic [NBANKS-1:0]                           fw_wr_i,
  input  logic [NBANKS-1:0]                           fw_mark_i,
  input  logic [NBANKS-1:0]                           ps_fwdone_gpi_i,
  input  logic                                        fw_err_clr_i,
  output logic [NBANKS-1:0]                           ps_fwupdate_gpo_o,
  output logic [NBANKS-1:0]                           fw_pscomplete_o,
  output logic [((NBANKS > 1) ? $clog2(NBANKS) : 1)-1:0] fw_next_bank_o,
  output logic [NBANKS-1:0]                           fw_err_o,
  output logic [NBANKS-1:0]                           fw_timeout_o,
  output logic [CNTW-1:0]                             fw_block_count_o
);

  localparam int NBW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ARM    = 3'd1,
    S_READY  = 3'd2,
    S_FILL   = 3'd3,
    S_MARKED = 3'd4
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [NBANKS-1:0] done, acc_mark, gpo_w, psc_w, err_w, to_w;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    state_t     state_q, state_d;
    logic [2:0] sync_q;
    logic       rise_q, pend_q, pend_d, err_set;
    logic       gpo_q, psc_q, err_q;

    // pend_q carries a write that arrived together with the completing rise.
    always_comb begin
      state_d = state_q;
      pend_d  = 1'b0;
      err_set = 1'b0;
      if (!fw_downloadmode_i) begin
        state_d = S_OFF;
      end else begin
        case (state_q)
          S_OFF:   state_d = S_ARM;
          S_ARM: begin
            err_set = fw_wr_i[b] | fw_mark_i[b];
            if (rise_q) state_d = S_READY;
          end
          S_READY: begin
            if (fw_mark_i[b])               state_d = S_MARKED;
            else if (fw_wr_i[b] || pend_q)  state_d = S_FILL;
          end
          S_FILL:  if (fw_mark_i[b]) state_d = S_MARKED;
          S_MARKED: begin
            if (rise_q) begin
              state_d = S_READY;
              pend_d  = fw_wr_i[b];
            end else if (fw_wr_i[b]) begin
              err_set = 1'b1;
            end
          end
          default: state_d = S_OFF;
        endcase
      end
    end

    always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
      if (!rst_int_n) begin
        state_q <= S_OFF;
        sync_q  <= 3'b000;
        rise_q  <= 1'b0;
        pend_q  <= 1'b0;
        gpo_q   <= 1'b0;
        psc_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sync_q  <= {sync_q[1:0], ps_fwdone_gpi_i[b]};
        rise_q  <= sync_q[1] & ~sync_q[2];
        pend_q  <= pend_d;
        gpo_q   <= (state_d == S_MARKED);
        psc_q   <= (state_d == S_READY);
        err_q   <= (err_q & ~fw_err_clr_i) | err_set;
      end
    end

    assign done[b]     = fw_downloadmode_i & rise_q & (state_q == S_MARKED);
    assign acc_mark[b] = fw_downloadmode_i & fw_mark_i[b] &
                         ((state_q == S_READY) || (state_q == S_FILL));
    assign gpo_w[b]    = gpo_q;
    assign psc_w[b]    = psc_q;
    assign err_w[b]    = err_q;

`ifdef FWU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;
    logic          to_q;

    always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
      if (!rst_int_n) begin
        tcnt_q <= '0;
        to_q   <= 1'b0;
      end else begin
        if (state_d == S_MARKED && state_q != S_MARKED)
          tcnt_q <= '0;
        else if (state_q == S_MARKED && tcnt_q != TW'(TIMEOUT_CYCLES))
          tcnt_q <= tcnt_q + TW'(1);
        to_q <= (to_q & ~fw_err_clr_i) |
                ((state_q == S_MARKED) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1)));
      end
    end
    assign to_w[b] = to_q;
`else
    assign to_w[b] = 1'b0;
`endif
  end

`ifndef FWU_TIMEOUT_EN
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  logic [CNTW-1:0] count_q, count_d, inc;
  logic [NBW-1:0]  next_q, next_d;

  always_comb begin
    inc = '0;
    for (int i = 0; i < NBANKS; i++) inc = inc + CNTW'(done[i]);
    count_d = fw_downloadmode_i ? (count_q + inc) : '0;
    next_d  = next_q;
    if (!fw_downloadmode_i)
      next_d = '0;
    else if (acc_mark[next_q])
      next_d = (next_q == NBW'(NBANKS - 1)) ? '0 : (next_q + NBW'(1));
  end

  always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      count_q <= '0;
      next_q  <= '0;
    end else begin
      count_q <= count_d;
      next_q  <= next_d;
    end
  end

  assign ps_fwupdate_gpo_o = gpo_w;
  assign fw_pscomplete_o   = psc_w;
  assign fw_err_o          = err_w;
  assign fw_timeout_o      = to_w;
  assign fw_next_bank_o    = next_q;
  assign fw_block_count_o  = count_q;

endmodule
`default_nettype wire
